// File: rtl/soc_system_pll_reset_sequencer.sv
// Supervises the system PLL: sequences its reset, qualifies the lock output and
// releases the per-domain resets in staggered order once lock has been stable.
module soc_system_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int NUM_DOMAINS         = 3,
  parameter int DOMAIN_STAGGER      = 8,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [RETRY_W-1:0]     retry_count,
  output logic [7:0]             lock_loss_count
);

  // RELEASE counts from 0 at entry; the step after the last domain release enters RUN.
  localparam int REL_LAST = (NUM_DOMAINS - 1) * DOMAIN_STAGGER + 1;
  localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD   = (LOCK_TIMEOUT_CYCLES > REL_LAST) ? LOCK_TIMEOUT_CYCLES : REL_LAST;
  localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_END     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_END = CNT_W'(REL_LAST);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [1:0]             sync_reg;
  logic                   pll_rst_reg;
  logic [NUM_DOMAINS-1:0] domain_rst_reg;
  logic                   ready_reg;
  logic                   fault_reg;
  logic [RETRY_W-1:0]     retry_reg;
  logic [7:0]             loss_reg;

  logic                   locked_s;
  logic                   lock_lost;
  logic                   relock_hit;
  logic                   restart;
  logic [NUM_DOMAINS-1:0] rel_hit;

  assign locked_s = sync_reg[1];

  // Domain gi is released when the RELEASE counter reaches gi*DOMAIN_STAGGER.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
      assign rel_hit[gi] = (cnt_reg == CNT_W'(gi * DOMAIN_STAGGER));
    end
  endgenerate

  always_comb begin
    lock_lost  = 1'b0;
    relock_hit = 1'b0;
    if ((state_reg == ST_RELEASE || state_reg == ST_RUN) && !locked_s)
      lock_lost = 1'b1;
    if (relock_req && state_reg != ST_PLL_RESET)
      relock_hit = 1'b1;
    restart = lock_lost | relock_hit;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg      <= ST_PLL_RESET;
      cnt_reg        <= '0;
      sync_reg       <= '0;
      pll_rst_reg    <= 1'b1;
      domain_rst_reg <= '1;
      ready_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      retry_reg      <= '0;
      loss_reg       <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
      if (restart) begin
        // A simultaneous relock and lock loss is one restart that still counts the loss.
        state_reg      <= ST_PLL_RESET;
        cnt_reg        <= '0;
        pll_rst_reg    <= 1'b1;
        domain_rst_reg <= '1;
        ready_reg      <= 1'b0;
        if (lock_lost && loss_reg != 8'hFF)
          loss_reg <= loss_reg + 8'd1;
        if (relock_hit) begin
          fault_reg <= 1'b0;
          retry_reg <= '0;
        end
      end else begin
        case (state_reg)
          ST_PLL_RESET: begin
            if (cnt_reg == RST_END) begin
              state_reg   <= ST_WAIT_LOCK;
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_s) begin
              state_reg <= ST_STABILIZE;
              cnt_reg   <= '0;
            end else if (cnt_reg == TIMEOUT_END) begin
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b1;
              if (retry_reg < RETRY_MAX) begin
                retry_reg <= retry_reg + 1'b1;
                state_reg <= ST_PLL_RESET;
              end else begin
                state_reg <= ST_FAULT;
                fault_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_STABILIZE: begin
            // A dropout is not a failed attempt: go back and wait with a fresh timeout.
            if (!locked_s) begin
              state_reg <= ST_WAIT_LOCK;
              cnt_reg   <= '0;
            end else if (cnt_reg == STABLE_END) begin
              state_reg <= ST_RELEASE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_RELEASE: begin
            domain_rst_reg <= domain_rst_reg & ~rel_hit;
            if (cnt_reg == RELEASE_END) begin
              state_reg <= ST_RUN;
              ready_reg <= 1'b1;
              retry_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_RUN: begin
            state_reg <= ST_RUN;
          end
          ST_FAULT: begin
            pll_rst_reg    <= 1'b1;
            domain_rst_reg <= '1;
          end
          default: begin
            state_reg   <= ST_PLL_RESET;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pll_rst         = pll_rst_reg;
  assign domain_rst      = domain_rst_reg;
  assign ready           = ready_reg;
  assign fault           = fault_reg;
  assign retry_count     = retry_reg;
  assign lock_loss_count = loss_reg;

endmodule

// File: tb/tb_soc_system_pll_reset_sequencer.sv
// Bench for the PLL reset sequencer: timing table, hand-written corner sequences
// and a randomized run against an elapsed-time reference model.
module tb_soc_system_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int S   = 8;
  localparam int T   = 32;
  localparam int MR  = 2;
  localparam int N   = 3;
  localparam int G   = 2;
  localparam int RW  = 2;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic [N-1:0]  domain_rst;
  logic          ready;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [7:0]    lock_loss_count;

  int cyc;
  int n_checks = 0;
  int n_pass = 0;

  always #5 refclk = ~refclk;

  soc_system_pll_reset_sequencer #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (S),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES        (MR),
    .NUM_DOMAINS        (N),
    .DOMAIN_STAGGER     (G)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .domain_rst     (domain_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs set here apply to this cycle.
  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  // On return the DUT sits in cycle 0: registers at reset values, rst low.
  task automatic do_reset();
    rst = 1'b1;
    relock_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_domain_rst"}, int'(domain_rst), 7);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_retry"}, int'(retry_count), 0);
    check({tag, "_loss"}, int'(lock_loss_count), 0);
  endtask

  task automatic wait_d0(input logic val, inout bit to);
    int k = 0;
    while (domain_rst[0] !== val && k < 100) begin
      step();
      k++;
    end
    if (domain_rst[0] !== val) begin
      n_checks++;
      to = 1'b1;
      $display("FAIL wait_d0 at cycle %0d: timed out, domain_rst=%b required bit0=%b", cyc, domain_rst, val);
    end
  endtask

  // ---------------- timing table ----------------
  typedef struct {
    int lock_at;
    int glitch_at;
    int d0;
    int d1;
    int d2;
    int rdy;
    int retry_at_d0;
  } row_t;

  row_t rows[6];

  // ---------------- reference model ----------------
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;
  int m_phase, m_t, m_retry, m_loss;
  bit hist[4096];

  function automatic int model_outputs(input int c);
    int dom = 0;
    int r;
    for (int i = 0; i < N; i++)
      if (!(m_phase == P_RUN || (m_phase == P_REL && c - m_t >= 1 + i * G)))
        dom = dom | (1 << i);
    r = (m_loss << 8) | (m_retry << 6) | (dom << 1);
    if (m_phase == P_FAULT) r = r | 32;
    if (m_phase == P_RUN) r = r | 16;
    if (m_phase == P_RST || m_phase == P_FAULT) r = r | 1;
    return r;
  endfunction

  // el = cycles already spent in the phase, including cycle c.
  task automatic model_advance(input int c, input bit ls, input bit rq);
    int nxt = m_phase;
    int el = c - m_t + 1;
    if (rq && m_phase != P_RST) begin
      if ((m_phase == P_REL || m_phase == P_RUN) && !ls && m_loss < 255) m_loss++;
      m_retry = 0;
      nxt = P_RST;
    end else begin
      case (m_phase)
        P_RST:  if (el == PRC) nxt = P_WAIT;
        P_WAIT: begin
          if (ls) nxt = P_STAB;
          else if (el == T) begin
            if (m_retry < MR) begin m_retry++; nxt = P_RST; end
            else nxt = P_FAULT;
          end
        end
        P_STAB: begin
          if (!ls) nxt = P_WAIT;
          else if (el == S) nxt = P_REL;
        end
        P_REL: begin
          if (!ls) begin if (m_loss < 255) m_loss++; nxt = P_RST; end
          else if (el == (N - 1) * G + 2) begin nxt = P_RUN; m_retry = 0; end
        end
        P_RUN: if (!ls) begin if (m_loss < 255) m_loss++; nxt = P_RST; end
        default: ;
      endcase
    end
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_t = c + 1;
    end
  endtask

  initial begin
    int td[N];
    int t_rdy, t_pll_fall, retry_d0;
    bit to;
    bit cur;
    int seg;
    int exp_v, act_v;
    bit ls;

    rows[0] = '{lock_at: 0,  glitch_at: -1, d0: 14, d1: 16, d2: 18, rdy: 19, retry_at_d0: 0};
    rows[1] = '{lock_at: 10, glitch_at: -1, d0: 22, d1: 24, d2: 26, rdy: 27, retry_at_d0: 0};
    rows[2] = '{lock_at: 10, glitch_at: 16, d0: 29, d1: 31, d2: 33, rdy: 34, retry_at_d0: 0};
    rows[3] = '{lock_at: 20, glitch_at: -1, d0: 32, d1: 34, d2: 36, rdy: 37, retry_at_d0: 0};
    rows[4] = '{lock_at: 33, glitch_at: -1, d0: 45, d1: 47, d2: 49, rdy: 50, retry_at_d0: 0};
    rows[5] = '{lock_at: 34, glitch_at: -1, d0: 50, d1: 52, d2: 54, rdy: 55, retry_at_d0: 1};

    for (int r = 0; r < 6; r++) begin
      do_reset();
      check_reset_values($sformatf("row%0d_reset", r));
      for (int i = 0; i < N; i++) td[i] = -1;
      t_rdy = -1;
      t_pll_fall = -1;
      retry_d0 = -1;
      for (int c = 0; c < 200; c++) begin
        if (t_pll_fall < 0 && !pll_rst) t_pll_fall = c;
        for (int i = 0; i < N; i++)
          if (td[i] < 0 && !domain_rst[i]) begin
            td[i] = c;
            if (i == 0) retry_d0 = int'(retry_count);
          end
        if (t_rdy < 0 && ready) t_rdy = c;
        pll_locked = (c >= rows[r].lock_at) && (c != rows[r].glitch_at);
        step();
      end
      $display("row %0d: lock_at=%0d glitch_at=%0d d0=%0d d1=%0d d2=%0d ready=%0d", r,
               rows[r].lock_at, rows[r].glitch_at, td[0], td[1], td[2], t_rdy);
      check($sformatf("row%0d_pll_rst_fall", r), t_pll_fall, PRC);
      check($sformatf("row%0d_d0_fall", r), td[0], rows[r].d0);
      check($sformatf("row%0d_d1_fall", r), td[1], rows[r].d1);
      check($sformatf("row%0d_d2_fall", r), td[2], rows[r].d2);
      check($sformatf("row%0d_ready_rise", r), t_rdy, rows[r].rdy);
      check($sformatf("row%0d_retry_at_d0", r), retry_d0, rows[r].retry_at_d0);
    end

    // Lock never arrives: two retries, then FAULT until relock_req.
    do_reset();
    pll_locked = 1'b0;
    goto_cycle(35);  check("fault_seq_retry35", int'(retry_count), 0);
    check("fault_seq_pll35", int'(pll_rst), 0);
    goto_cycle(36);  check("fault_seq_retry36", int'(retry_count), 1);
    check("fault_seq_pll36", int'(pll_rst), 1);
    goto_cycle(40);  check("fault_seq_pll40", int'(pll_rst), 0);
    goto_cycle(72);  check("fault_seq_retry72", int'(retry_count), 2);
    goto_cycle(107); check("fault_seq_fault107", int'(fault), 0);
    goto_cycle(108); check("fault_seq_fault108", int'(fault), 1);
    check("fault_seq_pll108", int'(pll_rst), 1);
    check("fault_seq_dom108", int'(domain_rst), 7);
    check("fault_seq_retry108", int'(retry_count), 2);
    goto_cycle(130); check("fault_seq_hold130", int'(fault), 1);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    check("fault_relock_fault", int'(fault), 0);
    check("fault_relock_retry", int'(retry_count), 0);
    check("fault_relock_pll", int'(pll_rst), 1);
    goto_cycle(134); check("fault_relock_pll134", int'(pll_rst), 1);
    goto_cycle(135); check("fault_relock_pll135", int'(pll_rst), 0);
    $display("seq fault: fault=%b retry=%0d at cycle %0d", fault, retry_count, cyc);

    // Lock loss in RUN, then a relock coinciding with a second loss.
    do_reset();
    pll_locked = 1'b1;
    goto_cycle(25); check("run_loss_ready25", int'(ready), 1);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    goto_cycle(27); check("run_loss_ready27", int'(ready), 1);
    check("run_loss_count27", int'(lock_loss_count), 0);
    goto_cycle(28); check("run_loss_dom28", int'(domain_rst), 7);
    check("run_loss_ready28", int'(ready), 0);
    check("run_loss_count28", int'(lock_loss_count), 1);
    check("run_loss_pll28", int'(pll_rst), 1);
    goto_cycle(31); check("run_loss_pll31", int'(pll_rst), 1);
    goto_cycle(32); check("run_loss_pll32", int'(pll_rst), 0);
    goto_cycle(46); check("rerun_ready46", int'(ready), 0);
    goto_cycle(47); check("rerun_ready47", int'(ready), 1);
    goto_cycle(50);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    goto_cycle(52);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    check("both_count53", int'(lock_loss_count), 2);
    check("both_dom53", int'(domain_rst), 7);
    check("both_pll53", int'(pll_rst), 1);
    goto_cycle(57); check("both_pll57", int'(pll_rst), 0);
    check("both_count57", int'(lock_loss_count), 2);
    $display("seq run loss: lock_loss_count=%0d at cycle %0d", lock_loss_count, cyc);

    // relock_req in RELEASE, then ignored in PLL_RESET.
    do_reset();
    pll_locked = 1'b1;
    goto_cycle(15); check("rel_relock_dom15", int'(domain_rst), 6);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    check("rel_relock_dom16", int'(domain_rst), 7);
    check("rel_relock_count16", int'(lock_loss_count), 0);
    check("rel_relock_pll16", int'(pll_rst), 1);
    goto_cycle(17);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    goto_cycle(19); check("rst_relock_pll19", int'(pll_rst), 1);
    goto_cycle(20); check("rst_relock_pll20", int'(pll_rst), 0);
    $display("seq relock: pll_rst=%b at cycle %0d", pll_rst, cyc);

    // 300 lock losses saturate the counter; then rst in RELEASE.
    do_reset();
    pll_locked = 1'b1;
    to = 1'b0;
    for (int k = 1; k <= 300 && !to; k++) begin
      wait_d0(1'b0, to);
      if (!to) begin
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_d0(1'b1, to);
      end
      if (k == 100 && !to) check("loss_count_100", int'(lock_loss_count), 100);
    end
    check("loss_count_sat", int'(lock_loss_count), 255);
    $display("seq saturation: lock_loss_count=%0d", lock_loss_count);
    wait_d0(1'b0, to);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("mid_release_rst");
    $display("seq mid-release rst: domain_rst=%b loss=%0d", domain_rst, lock_loss_count);

    // Randomized run against the reference model.
    do_reset();
    m_phase = P_RST;
    m_t = 0;
    m_retry = 0;
    m_loss = 0;
    cur = 1'b0;
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_v = model_outputs(c);
      act_v = int'({lock_loss_count, retry_count, fault, ready, domain_rst, pll_rst});
      check("rand_outputs", act_v, exp_v);
      if (seg == 0) begin
        cur = ~cur;
        if (cur) seg = $urandom_range(1, 90);
        else if ($urandom_range(0, 9) == 0) seg = $urandom_range(100, 160);
        else seg = $urandom_range(1, 6);
      end
      seg--;
      pll_locked = cur;
      relock_req = ($urandom_range(0, 149) == 0);
      hist[c] = cur;
      ls = (c >= 2) ? hist[c - 2] : 1'b0;
      model_advance(c, ls, relock_req);
      step();
    end
    relock_req = 1'b0;
    $display("random run: final model phase=%0d loss=%0d", m_phase, m_loss);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
